// File: rtl/lspc_irq_ctrl.sv
// LSPC control registers and interrupt controller: LSPCMODE/IRQACK/TIMERSTOP
// decode, IRQ pending latches with IPL encoding, and the auto-animation divider.
module lspc_irq_ctrl (
    input  logic        LSPC_6M,
    input  logic        RESETP,
    input  logic [15:0] M68K_DATA,
    input  logic        WR_LSPC_MODE,
    input  logic        WR_IRQ_ACK,
    input  logic        WR_TIMER_STOP,
    input  logic        TIMER_IRQ,
    input  logic        VBLANK_START,
    output logic [2:0]  TIMER_MODE,
    output logic        TIMER_IRQ_EN,
    output logic        TIMER_STOP,
    output logic [7:0]  AA_SPEED,
    output logic        AA_DISABLE,
    output logic [2:0]  AA_COUNT,
    output logic [2:0]  nIPL
);

    logic       wr_mode_q, wr_mode_d;
    logic       wr_ack_q, wr_ack_d;
    logic       wr_stop_q, wr_stop_d;
    logic       tirq_q, tirq_d;
    logic       vbl_q, vbl_d;

    logic [2:0] timer_mode_q, timer_mode_d;
    logic       timer_irq_en_q, timer_irq_en_d;
    logic       timer_stop_q, timer_stop_d;
    logic [7:0] aa_speed_q, aa_speed_d;
    logic       aa_disable_q, aa_disable_d;
    logic [2:0] aa_count_q, aa_count_d;
    logic [7:0] fdiv_q, fdiv_d;

    // pend[2]=cold reset, pend[1]=timer, pend[0]=vblank
    logic [2:0] pend_q, pend_d;
    logic [2:0] nipl_q, nipl_d;
    logic       ipl_arm_q, ipl_arm_d;

    logic       mode_we;
    logic       ack_we;
    logic       stop_we;
    logic       tirq_rise;
    logic       vbl_rise;
    logic [2:0] ack_clr;
    logic [2:0] ipl_enc;

    always_comb begin
        mode_we   = WR_LSPC_MODE & ~wr_mode_q;
        ack_we    = WR_IRQ_ACK & ~wr_ack_q;
        stop_we   = WR_TIMER_STOP & ~wr_stop_q;
        tirq_rise = TIMER_IRQ & ~tirq_q;
        vbl_rise  = VBLANK_START & ~vbl_q;
        ack_clr   = ack_we ? {M68K_DATA[0], M68K_DATA[1], M68K_DATA[2]}
                           : 3'b000;
    end

    always_comb begin
        wr_mode_d      = WR_LSPC_MODE;
        wr_ack_d       = WR_IRQ_ACK;
        wr_stop_d      = WR_TIMER_STOP;
        tirq_d         = TIMER_IRQ;
        vbl_d          = VBLANK_START;
        timer_mode_d   = timer_mode_q;
        timer_irq_en_d = timer_irq_en_q;
        timer_stop_d   = timer_stop_q;
        aa_speed_d     = aa_speed_q;
        aa_disable_d   = aa_disable_q;
        aa_count_d     = aa_count_q;
        fdiv_d         = fdiv_q;

        if (mode_we) begin
            aa_speed_d     = M68K_DATA[15:8];
            timer_mode_d   = M68K_DATA[7:5];
            timer_irq_en_d = M68K_DATA[4];
            aa_disable_d   = M68K_DATA[3];
        end

        if (stop_we) begin
            timer_stop_d = M68K_DATA[0];
        end

        // New AA_SPEED only lands on the next reload, never mid-count
        if (vbl_rise && !aa_disable_q) begin
            if (fdiv_q == 8'd0) begin
                fdiv_d     = aa_speed_q;
                aa_count_d = aa_count_q + 3'd1;
            end else begin
                fdiv_d = fdiv_q - 8'd1;
            end
        end
    end

    always_comb begin
        // Clear first so a same-cycle source edge wins
        pend_d    = pend_q & ~ack_clr;
        pend_d[1] = pend_d[1] | tirq_rise;
        pend_d[0] = pend_d[0] | vbl_rise;

        priority case (1'b1)
            pend_q[2]: ipl_enc = 3'b100;
            pend_q[1]: ipl_enc = 3'b101;
            pend_q[0]: ipl_enc = 3'b110;
            default:   ipl_enc = 3'b111;
        endcase

        // Hold IPL idle for the first edge after reset release
        ipl_arm_d = 1'b1;
        nipl_d    = ipl_arm_q ? ipl_enc : 3'b111;
    end

    always_ff @(posedge LSPC_6M or negedge RESETP) begin
        if (!RESETP) begin
            wr_mode_q      <= 1'b0;
            wr_ack_q       <= 1'b0;
            wr_stop_q      <= 1'b0;
            tirq_q         <= 1'b0;
            vbl_q          <= 1'b0;
            timer_mode_q   <= 3'b000;
            timer_irq_en_q <= 1'b0;
            timer_stop_q   <= 1'b0;
            aa_speed_q     <= 8'd0;
            aa_disable_q   <= 1'b0;
            aa_count_q     <= 3'd0;
            fdiv_q         <= 8'd0;
            pend_q         <= 3'b100;
            nipl_q         <= 3'b111;
            ipl_arm_q      <= 1'b0;
        end else begin
            wr_mode_q      <= wr_mode_d;
            wr_ack_q       <= wr_ack_d;
            wr_stop_q      <= wr_stop_d;
            tirq_q         <= tirq_d;
            vbl_q          <= vbl_d;
            timer_mode_q   <= timer_mode_d;
            timer_irq_en_q <= timer_irq_en_d;
            timer_stop_q   <= timer_stop_d;
            aa_speed_q     <= aa_speed_d;
            aa_disable_q   <= aa_disable_d;
            aa_count_q     <= aa_count_d;
            fdiv_q         <= fdiv_d;
            pend_q         <= pend_d;
            nipl_q         <= nipl_d;
            ipl_arm_q      <= ipl_arm_d;
        end
    end

    assign TIMER_MODE   = timer_mode_q;
    assign TIMER_IRQ_EN = timer_irq_en_q;
    assign TIMER_STOP   = timer_stop_q;
    assign AA_SPEED     = aa_speed_q;
    assign AA_DISABLE   = aa_disable_q;
    assign AA_COUNT     = aa_count_q;
    assign nIPL         = nipl_q;

endmodule

// File: tb/tb_lspc_irq_ctrl.sv
// Scoreboard bench for lspc_irq_ctrl: a behavioural model pushes expected
// output snapshots, which are popped and compared once the DUT has settled.
module tb_lspc_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data;
    logic        wr_mode, wr_ack, wr_stop, tirq, vbl;
    logic [2:0]  timer_mode;
    logic        timer_irq_en, timer_stop;
    logic [7:0]  aa_speed;
    logic        aa_disable;
    logic [2:0]  aa_count;
    logic [2:0]  nipl;

    lspc_irq_ctrl dut (
        .LSPC_6M      (clk),
        .RESETP       (rst_n),
        .M68K_DATA    (data),
        .WR_LSPC_MODE (wr_mode),
        .WR_IRQ_ACK   (wr_ack),
        .WR_TIMER_STOP(wr_stop),
        .TIMER_IRQ    (tirq),
        .VBLANK_START (vbl),
        .TIMER_MODE   (timer_mode),
        .TIMER_IRQ_EN (timer_irq_en),
        .TIMER_STOP   (timer_stop),
        .AA_SPEED     (aa_speed),
        .AA_DISABLE   (aa_disable),
        .AA_COUNT     (aa_count),
        .nIPL         (nipl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] nipl;
        logic [2:0] cnt;
        logic       stop;
        logic [2:0] mode;
        logic       en;
        logic [7:0] spd;
        logic       dis;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic [2:0] m_mode, m_cnt;
    logic       m_en, m_stop, m_dis;
    logic [7:0] m_spd, m_fdiv;
    logic       m_p3, m_p2, m_p1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] m_nipl();
        if (m_p3) return 3'b100;
        if (m_p2) return 3'b101;
        if (m_p1) return 3'b110;
        return 3'b111;
    endfunction

    task automatic model_reset();
        m_mode = 3'd0; m_en = 1'b0; m_stop = 1'b0; m_spd = 8'd0;
        m_dis = 1'b0;  m_cnt = 3'd0; m_fdiv = 8'd0;
        m_p3 = 1'b1;   m_p2 = 1'b0;  m_p1 = 1'b0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.nipl = m_nipl(); e.cnt = m_cnt; e.stop = m_stop; e.mode = m_mode;
        e.en = m_en; e.spd = m_spd; e.dis = m_dis;
        sb.push_back(e);
    endtask

    task automatic compare_next(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, ".nipl"}, 32'(nipl), 32'(e.nipl));
        check({tag, ".aa_count"}, 32'(aa_count), 32'(e.cnt));
        check({tag, ".timer_stop"}, 32'(timer_stop), 32'(e.stop));
        check({tag, ".timer_mode"}, 32'(timer_mode), 32'(e.mode));
        check({tag, ".irq_en"}, 32'(timer_irq_en), 32'(e.en));
        check({tag, ".aa_speed"}, 32'(aa_speed), 32'(e.spd));
        check({tag, ".aa_disable"}, 32'(aa_disable), 32'(e.dis));
    endtask

    task automatic observe(input string tag, input int n);
        push_exp();
        repeat (n) @(posedge clk);
        @(negedge clk);
        compare_next(tag);
    endtask

    // which: 0=LSPCMODE 1=IRQACK 2=TIMERSTOP
    task automatic wr(input int which, input logic [15:0] d, input int len);
        @(negedge clk);
        data = d;
        case (which)
            0: wr_mode = 1'b1;
            1: wr_ack = 1'b1;
            default: wr_stop = 1'b1;
        endcase
        repeat (len) @(posedge clk);
        case (which)
            0: begin
                m_spd = d[15:8]; m_mode = d[7:5]; m_en = d[4]; m_dis = d[3];
            end
            1: begin
                if (d[0]) m_p3 = 1'b0;
                if (d[1]) m_p2 = 1'b0;
                if (d[2]) m_p1 = 1'b0;
            end
            default: m_stop = d[0];
        endcase
        @(negedge clk);
        wr_mode = 1'b0; wr_ack = 1'b0; wr_stop = 1'b0;
    endtask

    task automatic aa_step();
        m_p1 = 1'b1;
        if (!m_dis) begin
            if (m_fdiv == 8'd0) begin
                m_fdiv = m_spd;
                m_cnt  = m_cnt + 3'd1;
            end else begin
                m_fdiv = m_fdiv - 8'd1;
            end
        end
    endtask

    task automatic vbl_pulse();
        @(negedge clk);
        vbl = 1'b1;
        @(posedge clk);
        aa_step();
        @(negedge clk);
        vbl = 1'b0;
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, ".nipl_edge1"}, 32'(nipl), 32'h7);
        observe({tag, ".edge2"}, 1);
        check({tag, ".nipl_is_100"}, 32'(nipl), 32'h4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; data = 16'h0;
        wr_mode = 1'b0; wr_ack = 1'b0; wr_stop = 1'b0;
        tirq = 1'b0; vbl = 1'b0;
        model_reset();
        m_p3 = 1'b0;
        repeat (3) @(posedge clk);
        observe("reset", 0);
        m_p3 = 1'b1;
        release_reset("boot");

        wr(1, 16'h0001, 1);
        check("ack_lat.n1", 32'(nipl), 32'h4);
        observe("ack_cold", 1);

        @(negedge clk);
        data = 16'hA5D8; wr_mode = 1'b1;
        @(posedge clk);
        m_spd = 8'hA5; m_mode = 3'b110; m_en = 1'b1; m_dis = 1'b1;
        observe("mode_n1", 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        wr_mode = 1'b0;
        observe("mode_hold", 1);

        @(negedge clk);
        tirq = 1'b1; vbl = 1'b1;
        @(posedge clk);
        m_p2 = 1'b1; aa_step();
        @(negedge clk);
        tirq = 1'b0; vbl = 1'b0;
        observe("both_src", 1);
        wr(1, 16'h0002, 1);
        observe("ack_timer", 1);
        wr(1, 16'h0004, 1);
        observe("ack_vbl", 1);

        @(negedge clk);
        data = 16'h0002; wr_ack = 1'b1; tirq = 1'b1;
        @(posedge clk);
        m_p2 = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0; tirq = 1'b0;
        observe("set_wins", 1);
        wr(1, 16'h0002, 1);
        observe("set_wins_clr", 1);

        // timer edge arrives while an ack strobe is still held
        @(negedge clk);
        data = 16'h0002; wr_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tirq = 1'b1;
        @(posedge clk);
        m_p2 = 1'b1;
        @(negedge clk);
        tirq = 1'b0;
        @(posedge clk);
        @(negedge clk);
        wr_ack = 1'b0;
        observe("ack_hold", 1);
        wr(1, 16'h0002, 1);
        wr(1, 16'h0007, 1);
        observe("ack_idle", 1);

        wr(2, 16'h0001, 1);
        observe("tstop", 1);

        wr(0, 16'h0200, 1);
        for (int i = 1; i <= 9; i++) begin
            vbl_pulse();
            observe($sformatf("aa_on%0d", i), 1);
        end
        check("aa_on_final", 32'(aa_count), 32'd3);
        wr(0, 16'h0208, 1);
        for (int i = 1; i <= 9; i++) begin
            vbl_pulse();
            observe($sformatf("aa_off%0d", i), 1);
        end
        check("aa_off_final", 32'(aa_count), 32'd3);

        wr(0, 16'h0200, 1);
        vbl_pulse();
        vbl_pulse();
        observe("pre_rst", 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst.timer_stop", 32'(timer_stop), 32'd0);
        check("arst.aa_count", 32'(aa_count), 32'd0);
        check("arst.nipl", 32'(nipl), 32'h7);
        model_reset();
        repeat (2) @(posedge clk);
        release_reset("mid");

        wr(1, 16'h0001, 1);
        wr(0, 16'h0200, 1);
        vbl_pulse();
        observe("fdiv_clr", 1);
        check("fdiv_clr.cnt", 32'(aa_count), 32'd1);
        wr(0, 16'h0000, 1);
        for (int i = 1; i <= 10; i++) begin
            vbl_pulse();
            observe($sformatf("aa_spd0_%0d", i), 1);
        end
        check("aa_wrap_final", 32'(aa_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
